// File: rtl/road_spawn_arbiter_pkg.sv
// Shared types for the road object spawn path: requester identities and
// the arbiter FSM encoding.
package road_pkg;

    localparam int NUM_REQ = 4;
    localparam int X_W     = 11;

    typedef enum logic [1:0] {
        OBJ_LEFT_CAR  = 2'd0,
        OBJ_RIGHT_CAR = 2'd1,
        OBJ_OIL       = 2'd2,
        OBJ_FUEL      = 2'd3
    } obj_type_e;

    typedef enum logic [1:0] {
        READY    = 2'd0,
        GRANT    = 2'd1,
        COOLDOWN = 2'd2
    } arb_state_e;

endpackage

// File: rtl/road_spawn_arbiter_rr_arbiter4.sv
// Four-way round-robin pick starting at ptr, with an override that hands
// the win to the fuel requester when it has starved.
module rr_arbiter4 (
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    input  logic       force_fuel,
    output logic [1:0] winner,
    output logic       valid
);
    import road_pkg::*;

    logic [1:0] idx;

    always_comb begin
        winner = ptr;
        idx    = ptr;
        valid  = |req;
        if (force_fuel && req[OBJ_FUEL]) begin
            winner = OBJ_FUEL;
        end else begin
            // Scan farthest-first so the requester closest to ptr overwrites last.
            for (int k = 3; k >= 0; k--) begin
                idx = ptr + 2'(k);
                if (req[idx]) winner = idx;
            end
        end
    end

endmodule

// File: rtl/road_spawn_arbiter.sv
// Per-frame spawn arbiter: grants one requester a free sprite slot per
// frame, enforces a global spawn gap and boosts a starving fuel request.
module road_spawn_arbiter #(
    parameter int NUM_SLOTS      = 4,
    parameter int MIN_GAP_FRAMES = 8,
    parameter int STARVE_FRAMES  = 60,
    parameter int X_W            = road_pkg::X_W
) (
    input  logic                     clk,
    input  logic                     resetN,
    input  logic                     frame_tick,
    input  logic                     straight_ahead,
    input  logic [3:0]               req,
    input  logic [4*X_W-1:0]         req_x,
    input  logic [NUM_SLOTS-1:0]     slot_done,
    output logic [3:0]               grant,
    output logic [NUM_SLOTS-1:0]     slot_spawn,
    output logic [NUM_SLOTS*2-1:0]   slot_type,
    output logic [NUM_SLOTS*X_W-1:0] slot_x,
    output logic [NUM_SLOTS-1:0]     slot_busy,
    output logic [7:0]               stall_count
);
    import road_pkg::*;

    localparam int SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam int GAP_W  = (MIN_GAP_FRAMES > 0) ? $clog2(MIN_GAP_FRAMES + 1) : 1;
    localparam int AGE_W  = (STARVE_FRAMES > 0) ? $clog2(STARVE_FRAMES + 1) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(MIN_GAP_FRAMES);
    localparam logic [AGE_W-1:0] AGE_MAX  = AGE_W'(STARVE_FRAMES);

    arb_state_e               state_q, state_d;
    logic [1:0]               rr_ptr_q, rr_ptr_d;
    logic [1:0]               win_q, win_d;
    logic [SLOT_W-1:0]        slot_q, slot_d;
    logic [GAP_W-1:0]         gap_cnt_q, gap_cnt_d;
    logic [AGE_W-1:0]         fuel_age_q, fuel_age_d;
    logic [NUM_SLOTS-1:0]     slot_busy_q, slot_busy_d;
    logic [NUM_SLOTS*2-1:0]   slot_type_q, slot_type_d;
    logic [NUM_SLOTS*X_W-1:0] slot_x_q, slot_x_d;
    logic [7:0]               stall_q, stall_d;

    logic [1:0]           arb_win;
    logic                 arb_valid;
    logic                 arb_fire;
    logic                 force_fuel;
    logic                 free_found;
    logic [SLOT_W-1:0]    free_idx;
    logic [X_W-1:0]       sel_x;
    logic [NUM_SLOTS-1:0] done_mask;

    assign force_fuel = (fuel_age_q >= AGE_MAX);

    rr_arbiter4 u_rr (
        .req       (req),
        .ptr       (rr_ptr_q),
        .force_fuel(force_fuel),
        .winner    (arb_win),
        .valid     (arb_valid)
    );

    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!slot_busy_q[i]) begin
                free_found = 1'b1;
                free_idx   = SLOT_W'(i);
            end
        end
    end

    always_comb begin
        sel_x = req_x[X_W-1:0];
        for (int r = 0; r < NUM_REQ; r++) begin
            if (arb_win == 2'(r)) sel_x = req_x[r*X_W +: X_W];
        end
    end

    always_comb begin
        grant      = '0;
        slot_spawn = '0;
        if (state_q == GRANT) begin
            grant[win_q]       = 1'b1;
            slot_spawn[slot_q] = 1'b1;
        end
    end

    // A done aimed at the slot being granted this cycle loses to the set.
    assign done_mask = slot_done & ~slot_spawn;
    assign arb_fire  = (state_q == READY) && frame_tick && straight_ahead && arb_valid;

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        win_d       = win_q;
        slot_d      = slot_q;
        gap_cnt_d   = gap_cnt_q;
        stall_d     = stall_q;
        slot_busy_d = slot_busy_q & ~done_mask;
        slot_type_d = slot_type_q;
        slot_x_d    = slot_x_q;
        fuel_age_d  = fuel_age_q;

        if (!req[OBJ_FUEL] || (state_q == GRANT && win_q == OBJ_FUEL)) begin
            fuel_age_d = '0;
        end else if (frame_tick && fuel_age_q != AGE_MAX) begin
            fuel_age_d = fuel_age_q + 1'b1;
        end

        case (state_q)
            READY: begin
                if (arb_fire) begin
                    if (free_found) begin
                        state_d   = GRANT;
                        win_d     = arb_win;
                        slot_d    = free_idx;
                        rr_ptr_d  = arb_win + 2'd1;
                        gap_cnt_d = GAP_LOAD;
                        for (int i = 0; i < NUM_SLOTS; i++) begin
                            if (free_idx == SLOT_W'(i)) begin
                                slot_busy_d[i]                = 1'b1;
                                slot_type_d[i*2 +: 2]         = arb_win;
                                slot_x_d[i*X_W +: X_W]        = sel_x;
                            end
                        end
                    end else if (stall_q != 8'hFF) begin
                        stall_d = stall_q + 8'd1;
                    end
                end
            end
            GRANT: begin
                state_d = (MIN_GAP_FRAMES > 0) ? COOLDOWN : READY;
            end
            COOLDOWN: begin
                if (frame_tick) begin
                    gap_cnt_d = gap_cnt_q - 1'b1;
                    if (gap_cnt_q <= GAP_W'(1)) state_d = READY;
                end
            end
            default: state_d = READY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            state_q     <= READY;
            rr_ptr_q    <= '0;
            win_q       <= '0;
            slot_q      <= '0;
            gap_cnt_q   <= '0;
            fuel_age_q  <= '0;
            slot_busy_q <= '0;
            slot_type_q <= '0;
            slot_x_q    <= '0;
            stall_q     <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            win_q       <= win_d;
            slot_q      <= slot_d;
            gap_cnt_q   <= gap_cnt_d;
            fuel_age_q  <= fuel_age_d;
            slot_busy_q <= slot_busy_d;
            slot_type_q <= slot_type_d;
            slot_x_q    <= slot_x_d;
            stall_q     <= stall_d;
        end
    end

    assign slot_busy   = slot_busy_q;
    assign slot_type   = slot_type_q;
    assign slot_x      = slot_x_q;
    assign stall_count = stall_q;

endmodule
